// File: rtl/instruction_sequencer.sv
// Decode/execute stage fed by program ROM at PC, driving the counter's jump interface.
// Optional SEQ_RETIRE_CNT_EN adds a saturating retired-instruction counter output.
module instruction_sequencer #(
   parameter int N       = 8,
   parameter int MEM_LAT = 1
) (
   input  logic         clk,
   input  logic         start,
   input  logic [N+2:0] instr,
   output logic [N-1:0] addr,
   output logic         JP,
   output logic         JF,
   output logic         Flag,
   output logic [N-1:0] acc,
   output logic         halted
`ifdef SEQ_RETIRE_CNT_EN
   ,
   output logic [15:0]  retired
`endif
);

   typedef enum logic [1:0] {S_FLUSH, S_RUN, S_HALT} state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_SUBI = 3'b011;
   localparam logic [2:0] OP_ANDI = 3'b100;
   localparam logic [2:0] OP_JMP  = 3'b101;
   localparam logic [2:0] OP_JMPF = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;
   localparam logic [1:0] LAT     = 2'(MEM_LAT);

   state_t       r_state, w_state_nxt;
   logic [1:0]   r_squash, w_squash_nxt;
   logic [N-1:0] r_acc, w_acc_nxt;
   logic         r_flag, w_flag_nxt;
   logic         w_jp, w_jf, w_alu, w_exec;
   logic [N-1:0] w_addr;
   logic [2:0]   w_opcode;
   logic [N-1:0] w_operand;

   assign w_opcode  = instr[N+2:N];
   assign w_operand = instr[N-1:0];

   always_comb begin
      w_state_nxt  = r_state;
      w_squash_nxt = r_squash;
      w_acc_nxt    = r_acc;
      w_flag_nxt   = r_flag;
      w_jp         = 1'b0;
      w_jf         = 1'b0;
      w_alu        = 1'b0;
      w_exec       = 1'b0;
      w_addr       = '0;
      case (r_state)
         S_FLUSH: begin
            w_squash_nxt = r_squash - 2'd1;
            if (r_squash == 2'd1)
               w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_exec = 1'b1;
            // X/unknown opcodes fall through to default and behave as NOP
            case (w_opcode)
               OP_LDI:  begin w_acc_nxt = w_operand;         w_alu = 1'b1; end
               OP_ADDI: begin w_acc_nxt = r_acc + w_operand; w_alu = 1'b1; end
               OP_SUBI: begin w_acc_nxt = r_acc - w_operand; w_alu = 1'b1; end
               OP_ANDI: begin w_acc_nxt = r_acc & w_operand; w_alu = 1'b1; end
               OP_JMP:  begin w_jp = 1'b1; w_addr = w_operand; end
               OP_JMPF: begin w_jf = 1'b1; w_addr = w_operand; end
               OP_HALT: w_state_nxt = S_HALT;
               default: ;
            endcase
            if (w_alu)
               w_flag_nxt = (w_acc_nxt == '0);
            // a redirect makes the MEM_LAT words already in the ROM pipe stale
            if (w_jp || (w_jf && r_flag)) begin
               w_state_nxt  = S_FLUSH;
               w_squash_nxt = LAT;
            end
         end
         S_HALT: ;
         default: w_state_nxt = S_FLUSH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (start) begin
         r_state  <= S_FLUSH;
         r_squash <= LAT;
         r_acc    <= '0;
         r_flag   <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_squash <= w_squash_nxt;
         r_acc    <= w_acc_nxt;
         r_flag   <= w_flag_nxt;
      end
   end

   assign JP     = w_jp & ~start;
   assign JF     = w_jf & ~start;
   assign addr   = start ? '0 : w_addr;
   assign Flag   = r_flag;
   assign acc    = r_acc;
   assign halted = (r_state == S_HALT);

`ifdef SEQ_RETIRE_CNT_EN
   logic [15:0] r_retired;
   always_ff @(posedge clk) begin
      if (start)
         r_retired <= '0;
      else if (w_exec && (r_retired != 16'hFFFF))
         r_retired <= r_retired + 16'd1;
   end
   assign retired = r_retired;
`endif

   a_opcode_known: assert property (@(posedge clk) disable iff (start)
      (r_state == S_RUN) |-> !$isunknown(w_opcode));

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench: a program-counter + ROM pipeline feeds the sequencer, an ISA-level
// interpreter with flush-bubble accounting predicts every output each cycle.
module tb_instruction_sequencer;

   localparam int N       = 8;
   localparam int MEM_LAT = 2;

   logic          clk = 1'b0;
   logic          start;
   logic [N+2:0]  instr;
   logic [N-1:0]  addr, acc;
   logic          JP, JF, Flag, halted;
`ifdef SEQ_RETIRE_CNT_EN
   logic [15:0]   retired;
`endif

   instruction_sequencer #(.N(N), .MEM_LAT(MEM_LAT)) dut (
      .clk    (clk),
      .start  (start),
      .instr  (instr),
      .addr   (addr),
      .JP     (JP),
      .JF     (JF),
      .Flag   (Flag),
      .acc    (acc),
      .halted (halted)
`ifdef SEQ_RETIRE_CNT_EN
      ,
      .retired(retired)
`endif
   );

   always #5 clk = ~clk;

   // program counter and ROM read pipeline
   logic [N+2:0] rom [256];
   logic [N-1:0] pc;
   logic [N+2:0] pipe [MEM_LAT];

   always @(posedge clk) begin
      if (start)                  pc <= '0;
      else if (JP || (JF && Flag)) pc <= addr;
      else                        pc <= pc + 8'd1;
      pipe[0] <= rom[pc];
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign instr = pipe[MEM_LAT-1];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // ISA-level reference state
   logic [7:0] m_pc, m_acc;
   logic       m_flag, m_halt;
   int         m_bub;
   int         m_ret;

   task automatic model_reset();
      m_pc = 0; m_acc = 0; m_flag = 1'b1; m_halt = 1'b0; m_bub = MEM_LAT; m_ret = 0;
   endtask

   task automatic run_cycle(input logic st);
      logic [10:0] w;
      logic [2:0]  op;
      logic [7:0]  d;
      logic        ejp, ejf;
      logic [7:0]  eaddr;
      start = st;
      @(negedge clk);
      w = rom[m_pc]; op = w[10:8]; d = w[7:0];
      ejp = 1'b0; ejf = 1'b0; eaddr = 8'h00;
      if (!st && !m_halt && m_bub == 0) begin
         if (op == 3'd5) begin ejp = 1'b1; eaddr = d; end
         if (op == 3'd6) begin ejf = 1'b1; eaddr = d; end
      end
      check("acc",    32'(acc),    32'(m_acc));
      check("Flag",   32'(Flag),   32'(m_flag));
      check("halted", 32'(halted), 32'(m_halt));
      check("JP",     32'(JP),     32'(ejp));
      check("JF",     32'(JF),     32'(ejf));
      check("addr",   32'(addr),   32'(eaddr));
`ifdef SEQ_RETIRE_CNT_EN
      check("retired", 32'(retired), 32'(m_ret));
`endif
      if (st) model_reset();
      else if (!m_halt) begin
         if (m_bub > 0) m_bub--;
         else begin
            if (m_ret < 65535) m_ret++;
            case (op)
               3'd1: begin m_acc = d;                   m_flag = (m_acc == 0); m_pc++; end
               3'd2: begin m_acc = 8'((m_acc + d) % 256); m_flag = (m_acc == 0); m_pc++; end
               3'd3: begin m_acc = 8'((m_acc + 256 - d) % 256); m_flag = (m_acc == 0); m_pc++; end
               3'd4: begin m_acc = m_acc & d;           m_flag = (m_acc == 0); m_pc++; end
               3'd5: begin m_pc = d; m_bub = MEM_LAT; end
               3'd6: if (m_flag) begin m_pc = d; m_bub = MEM_LAT; end else m_pc++;
               3'd7: m_halt = 1'b1;
               default: m_pc++;
            endcase
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] ins(input int op, input int d);
      return {3'(op), 8'(d)};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = ins(0, 0);
   endtask

   task automatic reset_and_run(input int cycles);
      run_cycle(1'b1);
      run_cycle(1'b1);
      for (int i = 0; i < cycles; i++) run_cycle(1'b0);
   endtask

   initial begin
      clear_rom();
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      model_reset();

      // LDI 5, ADDI 3, HALT
      clear_rom();
      rom[0] = ins(1, 5); rom[1] = ins(2, 3); rom[2] = ins(7, 0);
      reset_and_run(3 + MEM_LAT + 3);
      check("halt_acc", 32'(acc), 32'd8);

      // JMP 0x10 squashes ROM[1]
      clear_rom();
      rom[0] = ins(5, 8'h10); rom[1] = ins(1, 8'hFF); rom[2] = ins(1, 8'hFF);
      rom[8'h10] = ins(1, 7); rom[8'h11] = ins(7, 0);
      reset_and_run(12);
      check("jmp_acc", 32'(acc), 32'd7);

      // LDI 2, SUBI 2, JMPF 0x20 (taken)
      clear_rom();
      rom[0] = ins(1, 2); rom[1] = ins(3, 2); rom[2] = ins(6, 8'h20);
      rom[3] = ins(1, 8'h55); rom[4] = ins(1, 8'h66);
      rom[8'h20] = ins(2, 9); rom[8'h21] = ins(7, 0);
      reset_and_run(14);
      check("jmpf_acc", 32'(acc), 32'd9);

      // LDI 1, JMPF 0x20 (not taken), ADDI 1
      clear_rom();
      rom[0] = ins(1, 1); rom[1] = ins(6, 8'h20); rom[2] = ins(2, 1); rom[3] = ins(7, 0);
      reset_and_run(10);
      check("nojmpf_acc", 32'(acc), 32'd2);

      // wrap: LDI FF, ADDI 1
      clear_rom();
      rom[0] = ins(1, 8'hFF); rom[1] = ins(2, 1); rom[2] = ins(7, 0);
      reset_and_run(8);
      check("wrap_flag", 32'(Flag), 32'd1);

      // start asserted in the JMP cycle
      clear_rom();
      rom[0] = ins(1, 3); rom[1] = ins(5, 8'h40); rom[8'h40] = ins(7, 0);
      reset_and_run(MEM_LAT + 1);
      run_cycle(1'b1);
      run_cycle(1'b0);
      check("start_jmp_acc", 32'(acc), 32'd0);
      for (int i = 0; i < 8; i++) run_cycle(1'b0);

      // randomized programs with occasional mid-run start
      for (int p = 0; p < 40; p++) begin
         for (int i = 0; i < 256; i++) begin
            int op;
            op = $urandom_range(0, 7);
            if (op == 7 && $urandom_range(0, 7) != 0) op = $urandom_range(1, 4);
            rom[i] = ins(op, (op >= 2 && op <= 4 && $urandom_range(0, 1) == 1)
                             ? $urandom_range(0, 3) : $urandom_range(0, 255));
         end
         run_cycle(1'b1);
         for (int c = 0; c < 90; c++) run_cycle($urandom_range(0, 49) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
